cpu_run_ctrl: RTL

Run-control stage sitting directly downstream of the free-running clock generator: it takes the generated `clk` and produces the CPU's clock enable and CPU reset. It sequences a post-reset hold, then lets the bench or front panel start, stop, or single/multi-step the CPU. It also counts executed cycles and reacts to the CPU's halt signal.

---
 rtl/cpu_run_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run-control stage for the CPU. It runs on the generated clock and produces
// the CPU clock enable and CPU reset. After reset or a soft clear, it holds
// the CPU in reset for RST_CYCLES edges. It then waits in HALTED for a
// start (free-run) or step (run step_n cycles) command. It also counts
// enabled cycles and drops the enable when the CPU reports a halt.
//
// Ports
//   clk        in   clock, all logic on its rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   pulse: enter free-run
//   stop       in   pulse: halt at once
//   step       in   pulse: run step_n cycles, then halt
//   step_n     in   cycle count for step (0 behaves as 1)
//   clr        in   pulse: soft CPU reset, re-enters the reset hold
//   hlt_in     in   level from CPU, high once it executed a halt
//   cpu_en     out  registered CPU clock enable
//   cpu_rst_n  out  registered active-low CPU reset
//   running    out  high while in RUN or STEP
//   done       out  one-cycle pulse on every RUN/STEP -> HALTED transition
//   cycle_cnt  out  number of edges seen with cpu_en high (wraps)
//
// Handshake: there is no valid/ready pair here. Every command input is a
// level that is sampled at each rising edge. A command takes effect at
// the edge that samples it, and its effect on the registered outputs is
// visible in the following cycle.
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32,
    parameter int STEP_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic [STEP_W-1:0] step_n,
    input  logic              clr,
    input  logic              hlt_in,
    output logic              cpu_en,
    output logic              cpu_rst_n,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    // The hold counter starts at 0 after reset/clr, so the edge that sees
    // this value is the RST_CYCLES-th edge of the hold.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_HALTED = 2'd1,
        ST_RUN    = 2'd2,
        ST_STEP   = 2'd3
    } state_e;

    state_e             state_q,  state_d;
    logic [HOLD_W-1:0]  hold_q,   hold_d;
    logic [STEP_W-1:0]  remain_q, remain_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               en_q,     en_d;
    logic               rstn_q,   rstn_d;
    logic               run_q,    run_d;
    logic               done_q,   done_d;
    logic               halt_req;

    // stop and a CPU halt behave identically.
    assign halt_req = stop | hlt_in;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        // en_q is the enable the CPU sees during this cycle, so this edge
        // is an executed cycle exactly when en_q is high.
        cnt_d    = en_q ? cnt_q + CNT_W'(1) : cnt_q;

        if (clr) begin
            // A soft clear is not a normal halt: done stays low.
            state_d  = ST_RESET;
            hold_d   = '0;
            remain_d = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_HALTED;
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_q + HOLD_W'(1);
                    end
                end
                ST_HALTED: begin
                    if (!halt_req) begin
                        if (start) begin
                            state_d = ST_RUN;
                        end else if (step) begin
                            state_d  = ST_STEP;
                            remain_d = (step_n == '0) ? STEP_W'(1) : step_n;
                        end
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALTED;
                        done_d  = 1'b1;
                    end
                end
                ST_STEP: begin
                    remain_d = remain_q - STEP_W'(1);
                    if (halt_req || remain_q == STEP_W'(1)) begin
                        state_d  = ST_HALTED;
                        remain_d = '0;
                        done_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RESET;
                    hold_d  = '0;
                end
            endcase
        end

        // The outputs are derived from the next state, so they line up
        // with the state register.
        en_d   = (state_d == ST_RUN) || (state_d == ST_STEP);
        run_d  = en_d;
        rstn_d = (state_d != ST_RESET);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RESET;
            hold_q   <= '0;
            remain_q <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            rstn_q   <= 1'b0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            rstn_q   <= rstn_d;
            run_q    <= run_d;
            done_q   <= done_d;
        end
    end

    assign cpu_en    = en_q;
    assign cpu_rst_n = rstn_q;
    assign running   = run_q;
    assign done      = done_q;
    assign cycle_cnt = cnt_q;

endmodule
